// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push handshake, dispatch-side pop handshake and decoded head fields
interface decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int IMM_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic [XLEN-1:0]          in_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_pc;
    logic [4:0]               r1_addr;
    logic [4:0]               r2_addr;
    logic [4:0]               r3_addr;
    logic [4:0]               w1_addr;
    logic                     int_we;
    logic                     fp_we;
    logic [IMM_W-1:0]         imm;
    logic [1:0]               eu_type;
    logic                     sel_i_f;
    logic                     illegal;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, r1_addr, r2_addr, r3_addr, w1_addr,
               int_we, fp_we, imm, eu_type, sel_i_f, illegal, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, r1_addr, r2_addr, r3_addr, w1_addr,
               int_we, fp_we, imm, eu_type, sel_i_f, illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO with combinational RV64IMFD decode of the head entry
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int IMM_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign q.in_ready  = count_q < CW'(DEPTH);
    assign q.out_valid = count_q != '0;
    assign q.count     = count_q;
    assign push        = q.in_valid && q.in_ready;
    assign pop         = q.out_valid && q.out_ready;

    always_comb begin
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
        if (push) begin
            instr_q[wr_q] <= q.in_instr;
            pc_q[wr_q]    <= q.in_pc;
        end
    end

    // An empty queue presents a NOP so downstream sees a harmless, legal head
    logic [31:0] h;
    logic [6:0]  op;
    logic [4:0]  f5;
    logic        unused_funct3;

    assign h             = q.out_valid ? instr_q[rd_q] : 32'h0000_0013;
    assign q.out_pc      = q.out_valid ? pc_q[rd_q] : '0;
    assign op            = h[6:0];
    assign f5            = h[31:27];
    assign unused_funct3 = ^h[14:12];

    logic op_load, op_loadfp, op_opimm, op_auipc, op_opimm32, op_store, op_storefp;
    logic op_op, op_lui, op_op32, op_fmadd, op_fp, op_branch, op_jalr, op_jal;
    logic fp_to_int, legal, muldiv;
    logic [31:0] imm32;

    assign op_load    = op == 7'b0000011;
    assign op_loadfp  = op == 7'b0000111;
    assign op_opimm   = op == 7'b0010011;
    assign op_auipc   = op == 7'b0010111;
    assign op_opimm32 = op == 7'b0011011;
    assign op_store   = op == 7'b0100011;
    assign op_storefp = op == 7'b0100111;
    assign op_op      = op == 7'b0110011;
    assign op_lui     = op == 7'b0110111;
    assign op_op32    = op == 7'b0111011;
    assign op_fmadd   = op[6:4] == 3'b100 && op[1:0] == 2'b11;
    assign op_fp      = op == 7'b1010011;
    assign op_branch  = op == 7'b1100011;
    assign op_jalr    = op == 7'b1100111;
    assign op_jal     = op == 7'b1101111;

    assign legal = op_load | op_loadfp | op_opimm | op_auipc | op_opimm32 | op_store | op_storefp |
                   op_op | op_lui | op_op32 | op_fmadd | op_fp | op_branch | op_jalr | op_jal;

    // Compares, float-to-int converts and fmv.x/fclass land in the integer file
    assign fp_to_int = op_fp && (f5 == 5'b10100 || f5 == 5'b11000 || f5 == 5'b11100);
    assign muldiv    = ((op_op | op_op32) && h[31:25] == 7'b0000001) || op_fmadd ||
                       (op_fp && (f5 == 5'b00010 || f5 == 5'b00011 || f5 == 5'b01011));

    assign imm32 = (op_opimm | op_opimm32 | op_load | op_loadfp | op_jalr) ? {{20{h[31]}}, h[31:20]} :
                   (op_store | op_storefp) ? {{20{h[31]}}, h[31:25], h[11:7]} :
                   op_branch ? {{20{h[31]}}, h[7], h[30:25], h[11:8], 1'b0} :
                   (op_lui | op_auipc) ? {h[31:12], 12'b0} :
                   op_jal ? {{12{h[31]}}, h[19:12], h[20], h[30:21], 1'b0} : '0;

    assign q.imm     = IMM_W'($signed(imm32));
    assign q.r1_addr = h[19:15];
    assign q.r2_addr = h[24:20];
    assign q.r3_addr = h[31:27];
    assign q.w1_addr = h[11:7];
    assign q.illegal = !legal;
    assign q.sel_i_f = op_loadfp | op_storefp | op_fp | op_fmadd;
    assign q.fp_we   = op_loadfp | op_fmadd | (op_fp && !fp_to_int);
    assign q.int_we  = (op_op | op_op32 | op_opimm | op_opimm32 | op_lui | op_auipc | op_jal |
                        op_jalr | op_load | fp_to_int) && h[11:7] != 5'd0;
    assign q.eu_type = muldiv ? 2'd1 :
                       (op_jal | op_jalr | op_branch) ? 2'd2 :
                       (op_load | op_store | op_loadfp | op_storefp) ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table vectors, directed FIFO corner cases and random traffic against a queue model
module tb_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r1, r2, r3, w1;
        logic        int_we, fp_we;
        logic [31:0] imm;
        logic [1:0]  eu;
        logic        sel, ill;
    } dec_t;
    typedef struct packed {
        logic [31:0] instr;
        dec_t        d;
    } vec_t;
    typedef struct {
        logic [31:0] i;
        logic [63:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    ent_t mq[$];
    vec_t tbl[14];

    decode_queue_if #(.DEPTH(DEPTH), .XLEN(64), .IMM_W(32)) bus ();
    decode_queue #(.DEPTH(DEPTH), .XLEN(64), .IMM_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .q(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written opcode by opcode from the instruction-set rules
    function automatic dec_t ref_dec(input logic [31:0] i);
        dec_t d;
        logic [4:0] f5;
        f5 = i[31:27];
        d = '0;
        d.r1 = i[19:15];
        d.r2 = i[24:20];
        d.r3 = i[31:27];
        d.w1 = i[11:7];
        if (i[1:0] != 2'b11) begin
            d.ill = 1'b1;
            return d;
        end
        case (i[6:2])
            5'b00000: begin d.int_we = 1; d.eu = 3; d.imm = 32'($signed(i[31:20])); end
            5'b00001: begin d.fp_we = 1; d.eu = 3; d.sel = 1; d.imm = 32'($signed(i[31:20])); end
            5'b00100, 5'b00110: begin d.int_we = 1; d.imm = 32'($signed(i[31:20])); end
            5'b00101, 5'b01101: begin d.int_we = 1; d.imm = {i[31:12], 12'h000}; end
            5'b01000: begin d.eu = 3; d.imm = 32'($signed({i[31:25], i[11:7]})); end
            5'b01001: begin d.eu = 3; d.sel = 1; d.imm = 32'($signed({i[31:25], i[11:7]})); end
            5'b01100, 5'b01110: begin d.int_we = 1; d.eu = (i[31:25] == 7'd1) ? 2'd1 : 2'd0; end
            5'b10000, 5'b10001, 5'b10010, 5'b10011: begin d.fp_we = 1; d.eu = 1; d.sel = 1; end
            5'b10100: begin
                d.sel = 1;
                if (f5 inside {5'b10100, 5'b11000, 5'b11100}) d.int_we = 1;
                else d.fp_we = 1;
                if (f5 inside {5'b00010, 5'b00011, 5'b01011}) d.eu = 1;
            end
            5'b11000: begin d.eu = 2; d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            5'b11001: begin d.int_we = 1; d.eu = 2; d.imm = 32'($signed(i[31:20])); end
            5'b11011: begin d.int_we = 1; d.eu = 2; d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            default: d.ill = 1;
        endcase
        if (d.w1 == 5'd0) d.int_we = 0;
        return d;
    endfunction

    function automatic dec_t act_dec();
        return '{bus.r1_addr, bus.r2_addr, bus.r3_addr, bus.w1_addr, bus.int_we, bus.fp_we,
                 bus.imm, bus.eu_type, bus.sel_i_f, bus.illegal};
    endfunction

    task automatic check_model();
        logic [31:0]  hi;
        logic [63:0]  hp;
        logic [127:0] exp, act;
        hi = mq.size() != 0 ? mq[0].i : 32'h13;
        hp = mq.size() != 0 ? mq[0].pc : 64'h0;
        exp = {mq.size() != 0, mq.size() < DEPTH, 3'(mq.size()), hp, ref_dec(hi)};
        act = {bus.out_valid, bus.in_ready, bus.count, bus.out_pc, act_dec()};
        cmp("model", act, exp);
    endtask

    task automatic step();
        bit pu, po;
        @(posedge clk);
        pu = bus.in_valid && mq.size() < DEPTH;
        po = bus.out_ready && mq.size() > 0;
        if (rst || flush) mq.delete();
        else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back('{bus.in_instr, bus.in_pc});
        end
        #1;
        check_model();
    endtask

    task automatic push_n(input int n, input logic [63:0] base);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.in_instr = tbl[k].instr;
            bus.in_pc = base + 64'(4 * k);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h00500093, '{5'd0,  5'd5,  5'd0,  5'd1,  1'b1, 1'b0, 32'd5,        2'd0, 1'b0, 1'b0}};
        tbl[1]  = '{32'h02A484B3, '{5'd9,  5'd10, 5'd0,  5'd9,  1'b1, 1'b0, 32'd0,        2'd1, 1'b0, 1'b0}};
        tbl[2]  = '{32'hFE000EE3, '{5'd0,  5'd0,  5'd31, 5'd29, 1'b0, 1'b0, 32'hFFFFFFFC, 2'd2, 1'b0, 1'b0}};
        tbl[3]  = '{32'h12B57043, '{5'd10, 5'd11, 5'd2,  5'd0,  1'b0, 1'b1, 32'd0,        2'd1, 1'b1, 1'b0}};
        tbl[4]  = '{32'h00000000, '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        2'd0, 1'b0, 1'b1}};
        tbl[5]  = '{32'h123452B7, '{5'd8,  5'd3,  5'd2,  5'd5,  1'b1, 1'b0, 32'h12345000, 2'd0, 1'b0, 1'b0}};
        tbl[6]  = '{32'hFF813303, '{5'd2,  5'd24, 5'd31, 5'd6,  1'b1, 1'b0, 32'hFFFFFFF8, 2'd3, 1'b0, 1'b0}};
        tbl[7]  = '{32'h00713823, '{5'd2,  5'd7,  5'd0,  5'd16, 1'b0, 1'b0, 32'd16,       2'd3, 1'b0, 1'b0}};
        tbl[8]  = '{32'hC2209553, '{5'd1,  5'd2,  5'd24, 5'd10, 1'b1, 1'b0, 32'd0,        2'd0, 1'b1, 1'b0}};
        tbl[9]  = '{32'h1220F1D3, '{5'd1,  5'd2,  5'd2,  5'd3,  1'b0, 1'b1, 32'd0,        2'd1, 1'b1, 1'b0}};
        tbl[10] = '{32'h008000EF, '{5'd0,  5'd8,  5'd0,  5'd1,  1'b1, 1'b0, 32'd8,        2'd2, 1'b0, 1'b0}};
        tbl[11] = '{32'h00000001, '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        2'd0, 1'b0, 1'b1}};
        tbl[12] = '{32'h0000000F, '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        2'd0, 1'b0, 1'b1}};
        tbl[13] = '{32'h00000033, '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        2'd0, 1'b0, 1'b0}};

        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cmp("reset_count", bus.count, 0);
        cmp("reset_out_valid", bus.out_valid, 0);
        cmp("reset_in_ready", bus.in_ready, 1);
        cmp("reset_nop_decode", act_dec(), 58'h0);

        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00500093;
        bus.in_pc = 64'h1000;
        step();
        cmp("addi_valid", bus.out_valid, 1);
        cmp("addi_pc", bus.out_pc, 64'h1000);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();

        for (int k = 0; k < 14; k++) begin
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b0;
            bus.in_instr = tbl[k].instr;
            bus.in_pc = 64'h4000 + 64'(4 * k);
            step();
            cmp($sformatf("vec%0d", k), act_dec(), tbl[k].d);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            step();
        end

        push_n(4, 64'h2000);
        cmp("full_count", bus.count, 4);
        cmp("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_pc = 64'h2FFF;
        step();
        cmp("fifth_push_ignored", bus.count, 4);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("drain_pc%0d", k), bus.out_pc, 64'h2000 + 64'(4 * k));
            step();
        end
        cmp("drained_valid", bus.out_valid, 0);
        cmp("drained_count", bus.count, 0);

        push_n(4, 64'h3000);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_pc = 64'h3100;
        step();
        cmp("full_pop_only", bus.count, 3);
        for (int k = 0; k < 10; k++) begin
            bus.in_instr = tbl[k].instr;
            bus.in_pc = 64'h3200 + 64'(4 * k);
            step();
            cmp($sformatf("pushpop_count%0d", k), bus.count, 3);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();

        push_n(3, 64'h5000);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        cmp("flush_count", bus.count, 0);
        cmp("flush_valid", bus.out_valid, 0);

        push_n(3, 64'h6000);
        bus.out_ready = 1'b1;
        step();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        cmp("rst_mid_count", bus.count, 0);
        cmp("rst_mid_valid", bus.out_valid, 0);
        cmp("rst_mid_pc", bus.out_pc, 0);
        cmp("rst_mid_decode", act_dec(), 58'h0);

        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = ($urandom % 3) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            bus.in_instr = ($urandom % 2) != 0 ? tbl[$urandom % 14].instr : ($urandom | 32'h3);
            bus.in_pc = {$urandom, $urandom};
            flush = ($urandom % 40) == 0;
            rst = ($urandom % 300) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
